// File: rtl/pgm_pkg.sv
// rtl/pgm_pkg.sv - word format, header codes and FSM states for the packet generator
package pgm_pkg;

  localparam int WORD_W = 134;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD,
    GEN,
    GAP
  } pgm_state_t;

  function automatic logic [1:0] word_hdr(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 2];
  endfunction

endpackage

// File: rtl/pgm_gen_ram.sv
// rtl/pgm_gen_ram.sv - simple dual-port template RAM, one write port, registered read port
module pgm_gen_ram
  import pgm_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pgm_gen.sv
// rtl/pgm_gen.sv - packet bypass with template capture and replay generator
module pgm_gen
  import pgm_pkg::*;
#(
  parameter int  SLOTS      = 4,
  parameter int  SLOT_DEPTH = 32,
  parameter int  CNT_W      = 32,
  parameter int  GAP_W      = 16,
  localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [WORD_W-1:0] in_pgm_data,
  input  logic              in_pgm_data_wr,
  input  logic              in_pgm_valid_wr,
  input  logic              in_pgm_valid,
  output logic              out_pgm_alf,

  output logic [WORD_W-1:0] out_pgm_data,
  output logic              out_pgm_data_wr,
  output logic              out_pgm_valid_wr,
  output logic              out_pgm_valid,
  input  logic              in_pgm_alf,

  input  logic              cfg_load,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [GAP_W-1:0]  cfg_gap,

  output logic              out_pgm_sent_start_flag,
  output logic              out_pgm_sent_finish_flag,
  output logic              out_pgm_busy,
  output logic [CNT_W-1:0]  out_pgm_sent_cnt,
  output logic              out_pgm_load_err
);

  localparam int LEN_W  = $clog2(SLOT_DEPTH + 1);
  localparam int ADDR_W = (SLOTS * SLOT_DEPTH > 1) ? $clog2(SLOTS * SLOT_DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(SLOT_DEPTH);

  pgm_state_t state, state_nxt;

  logic [LEN_W-1:0]  slot_len [SLOTS];
  logic [SLOT_W-1:0] load_slot, run_slot;
  logic [LEN_W-1:0]  load_idx, wr_idx, rd_idx, run_len;
  logic              load_ovf, load_err;
  logic [CNT_W-1:0]  run_count, sent_cnt;
  logic [GAP_W-1:0]  run_gap, gap_cnt;
  logic              stop_req, stop_any, pkt_active, last_pkt, start_ok;
  logic              in_head, in_tail;
  logic              rd_en, tail_rd, start_go, finish;
  logic              rd_vld, rd_last;
  logic              byp_en, ram_we, busy;
  logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
  logic [WORD_W-1:0] ram_rd_data;
  logic [WORD_W-1:0] byp_data;
  logic              byp_wr, byp_vwr, byp_v;
  logic              start_flag, finish_flag;

  assign in_head    = in_pgm_data_wr && (word_hdr(in_pgm_data) == HDR_HEAD);
  assign in_tail    = in_pgm_data_wr && (word_hdr(in_pgm_data) == HDR_TAIL);
  assign stop_any   = stop_req | cfg_stop;
  // rd_idx returns to zero after every tail, so nonzero means mid-packet
  assign pkt_active = (rd_idx != '0);
  assign last_pkt   = (run_count != '0) && ((sent_cnt + CNT_W'(1)) == run_count);
  assign start_ok   = (slot_len[cfg_slot] >= LEN_W'(2));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    tail_rd   = 1'b0;
    start_go  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (start_ok) begin
            start_go  = 1'b1;
            state_nxt = GEN;
          end
        end else if (cfg_load) begin
          state_nxt = LOAD_WAIT;
        end
      end
      LOAD_WAIT: if (in_head) state_nxt = LOAD;
      LOAD:      if (in_tail) state_nxt = IDLE;
      GEN: begin
        if (pkt_active) begin
          rd_en = 1'b1;
          if (rd_idx == run_len - LEN_W'(1)) begin
            tail_rd = 1'b1;
            if (last_pkt || stop_any) begin
              finish    = 1'b1;
              state_nxt = IDLE;
            end else if (run_gap != '0) begin
              state_nxt = GAP;
            end
          end
        end else if (stop_any) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (!in_pgm_alf) begin
          rd_en = 1'b1;
        end
      end
      GAP: begin
        if (stop_any) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_nxt = GEN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    byp_en = 1'b0;
    ram_we = 1'b0;
    case (state)
      IDLE:      byp_en = 1'b1;
      LOAD_WAIT: begin
        byp_en = 1'b1;
        ram_we = in_head;
      end
      LOAD: begin
        byp_en = 1'b1;
        ram_we = in_pgm_data_wr && (load_idx < DEPTH_L);
      end
      GEN, GAP:  busy = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  assign wr_idx      = (state == LOAD) ? load_idx : '0;
  assign ram_wr_addr = ADDR_W'(load_slot) * ADDR_W'(SLOT_DEPTH) + ADDR_W'(wr_idx);
  assign ram_rd_addr = ADDR_W'(run_slot) * ADDR_W'(SLOT_DEPTH) + ADDR_W'(rd_idx);

  pgm_gen_ram #(
    .DEPTH  (SLOTS * SLOT_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_wr_addr),
    .wr_data (in_pgm_data),
    .rd_en   (rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // A slot reads as empty while it is being rewritten and after any overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      load_slot <= '0;
      load_idx  <= '0;
      load_ovf  <= 1'b0;
      load_err  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) slot_len[i] <= '0;
    end else begin
      if (state == IDLE && state_nxt == LOAD_WAIT) load_slot <= cfg_slot;
      if (state == LOAD_WAIT && in_head) begin
        load_idx            <= LEN_W'(1);
        load_ovf            <= 1'b0;
        slot_len[load_slot] <= '0;
      end
      if (state == LOAD && in_pgm_data_wr) begin
        if (load_idx < DEPTH_L) begin
          load_idx <= load_idx + LEN_W'(1);
        end else begin
          load_ovf <= 1'b1;
          load_err <= 1'b1;
        end
        if (in_tail)
          slot_len[load_slot] <= (load_ovf || load_idx == DEPTH_L) ? '0 : load_idx + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_slot  <= '0;
      run_len   <= '0;
      run_count <= '0;
      run_gap   <= '0;
      gap_cnt   <= '0;
      rd_idx    <= '0;
      sent_cnt  <= '0;
      stop_req  <= 1'b0;
    end else if (start_go) begin
      run_slot  <= cfg_slot;
      run_len   <= slot_len[cfg_slot];
      run_count <= cfg_count;
      run_gap   <= cfg_gap;
      sent_cnt  <= '0;
      rd_idx    <= '0;
      stop_req  <= 1'b0;
    end else begin
      if (rd_en) rd_idx <= tail_rd ? '0 : rd_idx + LEN_W'(1);
      if (tail_rd) sent_cnt <= sent_cnt + CNT_W'(1);
      if (finish)                stop_req <= 1'b0;
      else if (cfg_stop && busy) stop_req <= 1'b1;
      if (tail_rd)               gap_cnt <= run_gap;
      else if (state == GAP)     gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Bypass registers are zero outside bypass so the generator path can OR in
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld      <= 1'b0;
      rd_last     <= 1'b0;
      start_flag  <= 1'b0;
      finish_flag <= 1'b0;
      byp_data    <= '0;
      byp_wr      <= 1'b0;
      byp_vwr     <= 1'b0;
      byp_v       <= 1'b0;
    end else begin
      rd_vld      <= rd_en;
      rd_last     <= tail_rd;
      start_flag  <= start_go;
      finish_flag <= finish;
      if (byp_en) begin
        byp_data <= in_pgm_data;
        byp_wr   <= in_pgm_data_wr;
        byp_vwr  <= in_pgm_valid_wr;
        byp_v    <= in_pgm_valid;
      end else begin
        byp_data <= '0;
        byp_wr   <= 1'b0;
        byp_vwr  <= 1'b0;
        byp_v    <= 1'b0;
      end
    end
  end

  assign out_pgm_data             = rd_vld ? ram_rd_data : byp_data;
  assign out_pgm_data_wr          = rd_vld | byp_wr;
  assign out_pgm_valid_wr         = (rd_vld & rd_last) | byp_vwr;
  assign out_pgm_valid            = (rd_vld & rd_last) | byp_v;
  assign out_pgm_alf              = busy | in_pgm_alf;
  assign out_pgm_busy             = busy;
  assign out_pgm_sent_cnt         = sent_cnt;
  assign out_pgm_load_err         = load_err;
  assign out_pgm_sent_start_flag  = start_flag;
  assign out_pgm_sent_finish_flag = finish_flag;

endmodule

// File: tb/tb_pgm_gen.sv
// tb/tb_pgm_gen.sv - vector table for bypass plus directed load/generate sequences for pgm_gen
module tb_pgm_gen;
  import pgm_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [WORD_W-1:0] BW0 = {2'b01, 132'h0A0};
  localparam logic [WORD_W-1:0] BW1 = {2'b11, 132'h0A1};
  localparam logic [WORD_W-1:0] BW2 = {2'b10, 132'h0A2};
  localparam logic [WORD_W-1:0] BX0 = {2'b01, 132'h5B0};
  localparam logic [WORD_W-1:0] BX1 = {2'b10, 132'h5B1};
  localparam logic [WORD_W-1:0] Z   = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WORD_W-1:0] in_pgm_data = '0;
  logic              in_pgm_data_wr = 1'b0, in_pgm_valid_wr = 1'b0, in_pgm_valid = 1'b0;
  logic              out_pgm_alf;
  logic [WORD_W-1:0] out_pgm_data;
  logic              out_pgm_data_wr, out_pgm_valid_wr, out_pgm_valid;
  logic              in_pgm_alf = 1'b0;
  logic              cfg_load = 1'b0, cfg_start = 1'b0, cfg_stop = 1'b0;
  logic [1:0]        cfg_slot = '0;
  logic [31:0]       cfg_count = '0;
  logic [15:0]       cfg_gap = '0;
  logic              out_pgm_sent_start_flag, out_pgm_sent_finish_flag, out_pgm_busy;
  logic [31:0]       out_pgm_sent_cnt;
  logic              out_pgm_load_err;

  pgm_gen dut (
    .clk                      (clk),
    .rst                      (rst),
    .in_pgm_data              (in_pgm_data),
    .in_pgm_data_wr           (in_pgm_data_wr),
    .in_pgm_valid_wr          (in_pgm_valid_wr),
    .in_pgm_valid             (in_pgm_valid),
    .out_pgm_alf              (out_pgm_alf),
    .out_pgm_data             (out_pgm_data),
    .out_pgm_data_wr          (out_pgm_data_wr),
    .out_pgm_valid_wr         (out_pgm_valid_wr),
    .out_pgm_valid            (out_pgm_valid),
    .in_pgm_alf               (in_pgm_alf),
    .cfg_load                 (cfg_load),
    .cfg_slot                 (cfg_slot),
    .cfg_start                (cfg_start),
    .cfg_stop                 (cfg_stop),
    .cfg_count                (cfg_count),
    .cfg_gap                  (cfg_gap),
    .out_pgm_sent_start_flag  (out_pgm_sent_start_flag),
    .out_pgm_sent_finish_flag (out_pgm_sent_finish_flag),
    .out_pgm_busy             (out_pgm_busy),
    .out_pgm_sent_cnt         (out_pgm_sent_cnt),
    .out_pgm_load_err         (out_pgm_load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WORD_W-1:0] cap_data[$];
  int                cap_cyc[$];
  logic              cap_vwr[$];
  int start_cnt = 0, finish_cnt = 0, start_cyc = -1, finish_cyc = -1;

  always @(negedge clk) begin
    if (out_pgm_data_wr) begin
      cap_data.push_back(out_pgm_data);
      cap_cyc.push_back(cyc);
      cap_vwr.push_back(out_pgm_valid_wr);
    end
    if (out_pgm_sent_start_flag) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (out_pgm_sent_finish_flag) begin
      finish_cnt++;
      finish_cyc = cyc;
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mkw(input int idx, input int len, input int base);
    logic [1:0] hdr;
    hdr = (idx == 0) ? HDR_HEAD : (idx == len - 1) ? HDR_TAIL : HDR_MID;
    return {hdr, 100'd0, 32'(base + idx)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_data.delete();
    cap_cyc.delete();
    cap_vwr.delete();
    start_cnt  = 0;
    finish_cnt = 0;
    start_cyc  = -1;
    finish_cyc = -1;
  endtask

  task automatic send_pkt(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      in_pgm_data     = mkw(i, len, base);
      in_pgm_data_wr  = 1'b1;
      in_pgm_valid_wr = (i == len - 1);
      in_pgm_valid    = (i == len - 1);
      tick();
    end
    in_pgm_data     = '0;
    in_pgm_data_wr  = 1'b0;
    in_pgm_valid_wr = 1'b0;
    in_pgm_valid    = 1'b0;
    tick();
  endtask

  task automatic pulse_load(input logic [1:0] slot);
    cfg_slot = slot;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] slot, input int cnt, input int gap, output int s);
    cfg_slot  = slot;
    cfg_count = cnt;
    cfg_gap   = gap[15:0];
    cfg_start = 1'b1;
    tick();
    s = cyc;
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (out_pgm_busy && n < max) begin
      tick();
      n++;
    end
    check(name, out_pgm_busy, 0);
    tick();
    tick();
  endtask

  function automatic int count_vwr();
    int n = 0;
    foreach (cap_vwr[k]) if (cap_vwr[k]) n++;
    return n;
  endfunction

  typedef struct {
    logic [WORD_W-1:0] d;
    logic              wr, vwr, v, alf;
    logic [WORD_W-1:0] exp_d;
    logic              exp_wr, exp_vwr, exp_v, exp_alf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;

    // bypass vectors: outputs one cycle behind inputs, alf combinational
    vecs[0] = '{Z,   L, L, L, L, Z,   L, L, L, L};
    vecs[1] = '{BW0, H, L, L, L, BW0, H, L, L, L};
    vecs[2] = '{BW1, H, L, L, H, BW1, H, L, L, H};
    vecs[3] = '{BW2, H, H, H, L, BW2, H, H, H, L};
    vecs[4] = '{Z,   L, L, L, H, Z,   L, L, L, H};
    vecs[5] = '{BX0, H, L, L, L, BX0, H, L, L, L};
    vecs[6] = '{BX1, H, H, L, L, BX1, H, H, L, L};
    vecs[7] = '{Z,   L, L, L, L, Z,   L, L, L, L};

    rst = 1'b1;
    tick();
    tick();
    check("rst_data", out_pgm_data, 0);
    check("rst_data_wr", out_pgm_data_wr, 0);
    check("rst_valid_wr", out_pgm_valid_wr, 0);
    check("rst_busy", out_pgm_busy, 0);
    check("rst_sent_cnt", out_pgm_sent_cnt, 0);
    check("rst_load_err", out_pgm_load_err, 0);
    check("rst_flags", {out_pgm_sent_start_flag, out_pgm_sent_finish_flag}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      in_pgm_data     = vecs[i].d;
      in_pgm_data_wr  = vecs[i].wr;
      in_pgm_valid_wr = vecs[i].vwr;
      in_pgm_valid    = vecs[i].v;
      in_pgm_alf      = vecs[i].alf;
      tick();
      check($sformatf("byp%0d_data", i), out_pgm_data, vecs[i].exp_d);
      check($sformatf("byp%0d_data_wr", i), out_pgm_data_wr, vecs[i].exp_wr);
      check($sformatf("byp%0d_valid_wr", i), out_pgm_valid_wr, vecs[i].exp_vwr);
      check($sformatf("byp%0d_valid", i), out_pgm_valid, vecs[i].exp_v);
      check($sformatf("byp%0d_alf", i), out_pgm_alf, vecs[i].exp_alf);
    end
    in_pgm_alf = 1'b0;

    // capture a 4-word template into slot 2; it still bypasses
    clear_cap();
    pulse_load(2'd2);
    send_pkt(4, 'h100);
    check("load_byp_words", cap_data.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < cap_data.size()) check($sformatf("load_byp_w%0d", k), cap_data[k], mkw(k, 4, 'h100));
    check("load_err_clean", out_pgm_load_err, 0);

    // count 3, gap 5; cfg changes after the start pulse must not matter
    clear_cap();
    pulse_start(2'd2, 3, 5, s);
    cfg_count = 0;
    cfg_gap   = 0;
    check("gen_busy", out_pgm_busy, 1);
    check("gen_alf", out_pgm_alf, 1);
    wait_idle("gen_done", 300);
    check("gen_words", cap_data.size(), 12);
    if (cap_data.size() >= 12) begin
      for (int k = 0; k < 12; k++) check($sformatf("gen_w%0d", k), cap_data[k], mkw(k % 4, 4, 'h100));
      check("gen_first_cyc", cap_cyc[0], s + 1);
      check("gen_pkt_contig", cap_cyc[3] - cap_cyc[0], 3);
      check("gen_gap1", cap_cyc[4] - cap_cyc[3], 6);
      check("gen_gap2", cap_cyc[8] - cap_cyc[7], 6);
      check("gen_finish_cyc", finish_cyc, cap_cyc[11]);
    end
    check("gen_tails", count_vwr(), 3);
    check("gen_sent_cnt", out_pgm_sent_cnt, 3);
    check("gen_start_cnt", start_cnt, 1);
    check("gen_start_cyc", start_cyc, s);
    check("gen_finish_cnt", finish_cnt, 1);

    // overflow a slot: 40 words into 32 entries
    pulse_load(2'd1);
    send_pkt(40, 'h200);
    check("ovf_load_err", out_pgm_load_err, 1);
    clear_cap();
    pulse_start(2'd1, 1, 0, s);
    check("ovf_start_ignored", out_pgm_busy, 0);
    tick();
    check("ovf_no_words", cap_data.size(), 0);
    check("ovf_no_start_flag", start_cnt, 0);

    // back-pressure: raised mid-packet, held through the gap
    clear_cap();
    pulse_start(2'd2, 2, 3, s);
    tick();
    tick();
    in_pgm_alf = 1'b1;
    repeat (13) tick();
    check("bp_still_busy", out_pgm_busy, 1);
    in_pgm_alf = 1'b0;
    wait_idle("bp_done", 300);
    check("bp_words", cap_data.size(), 8);
    if (cap_data.size() >= 8) begin
      check("bp_pkt1_tail_cyc", cap_cyc[3], s + 4);
      check("bp_pkt2_head_cyc", cap_cyc[4], s + 16);
      check("bp_pkt2_head", cap_data[4], mkw(0, 4, 'h100));
    end
    check("bp_sent_cnt", out_pgm_sent_cnt, 2);

    // continuous, back-to-back, stop in the middle of packet 7
    clear_cap();
    pulse_start(2'd2, 0, 0, s);
    repeat (26) tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_idle("stop_done", 300);
    check("stop_words", cap_data.size(), 28);
    if (cap_data.size() >= 28) begin
      check("stop_span", cap_cyc[27] - cap_cyc[0], 27);
      check("stop_last_cyc", cap_cyc[27], s + 28);
      check("stop_last_word", cap_data[27], mkw(3, 4, 'h100));
    end
    check("stop_finish_cyc", finish_cyc, s + 28);
    check("stop_finish_cnt", finish_cnt, 1);
    check("stop_tails", count_vwr(), 7);
    check("stop_sent_cnt", out_pgm_sent_cnt, 7);

    // reset in the middle of the second packet
    pulse_start(2'd2, 0, 0, s);
    repeat (6) tick();
    check("pre_rst_busy", out_pgm_busy, 1);
    rst = 1'b1;
    tick();
    check("midrst_data", out_pgm_data, 0);
    check("midrst_data_wr", out_pgm_data_wr, 0);
    check("midrst_valid", {out_pgm_valid_wr, out_pgm_valid}, 0);
    check("midrst_busy", out_pgm_busy, 0);
    check("midrst_alf", out_pgm_alf, 0);
    check("midrst_sent_cnt", out_pgm_sent_cnt, 0);
    check("midrst_load_err", out_pgm_load_err, 0);
    rst = 1'b0;
    tick();
    clear_cap();
    pulse_start(2'd2, 3, 0, s);
    check("midrst_slot_empty", out_pgm_busy, 0);
    tick();
    check("midrst_no_words", cap_data.size(), 0);
    check("midrst_no_start", start_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
